lc3_datapath: RTL

Datapath for the LC-3 subset CPU. It sits directly downstream of the instruction sequencer/decoder: it consumes that unit's load, gate and mux-select strobes and returns Opcode, IR_5, IR_11 and BEN. It holds PC, MAR, MDR, IR, the register file, condition codes, BEN and the PAUSE LED register, and drives a single internal 16-bit bus. It connects to the SRAM interface through MAR, MDR and Data_from_SRAM.

---
 rtl/lc3_pkg.sv | 41 ++++
 rtl/lc3_reg_file.sv | 32 +++
 rtl/lc3_datapath.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 encodings and helpers used by the datapath and the sequencer.
package lc3_pkg;

    localparam logic [1:0] ALUK_PASS = 2'b00;
    localparam logic [1:0] ALUK_ADD  = 2'b01;
    localparam logic [1:0] ALUK_AND  = 2'b10;
    localparam logic [1:0] ALUK_NOT  = 2'b11;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;
    localparam logic [1:0] PCMUX_HOLD = 2'b11;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_JSR = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_PSE = 4'hD;

    // Sign-extend the low w bits of v to 16 bits.
    function automatic logic [15:0] sext(input logic [15:0] v, input int unsigned w);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 16; i++) begin
            if (i >= int'(w)) r[i] = v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/lc3_reg_file.sv
// LC-3 general register file: R0-R7, one write port, two combinational read ports.
module lc3_reg_file (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [2:0]  raddr1,
    input  logic [2:0]  raddr2,
    output logic [15:0] rdata1,
    output logic [15:0] rdata2
);
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-write value when write and read hit the same register.
    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];
endmodule

// File: rtl/lc3_datapath.sv
// LC-3 datapath: PC/MAR/MDR/IR, register file, ALU, address adder and shared bus.
// Define LC3_BUS_CHECK_EN to enable the sticky bus-contention flag Bus_Err.
module lc3_datapath
    import lc3_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        LD_IR,
    input  logic        LD_BEN,
    input  logic        LD_CC,
    input  logic        LD_REG,
    input  logic        LD_PC,
    input  logic        LD_LED,
    input  logic        GatePC,
    input  logic        GateMDR,
    input  logic        GateALU,
    input  logic        GateMARMUX,
    input  logic [1:0]  PCMUX,
    input  logic        DRMUX,
    input  logic        SR1MUX,
    input  logic        SR2MUX,
    input  logic        ADDR1MUX,
    input  logic [1:0]  ADDR2MUX,
    input  logic [1:0]  ALUK,
    input  logic        Mem_OE,
    input  logic [15:0] Data_from_SRAM,
    output logic [3:0]  Opcode,
    output logic        IR_5,
    output logic        IR_11,
    output logic        BEN,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] PC_out,
    output logic [15:0] IR_out,
    output logic [11:0] LED,
    output logic        Bus_Err
);
    logic [15:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d;
    logic [11:0] led_q, led_d;
    logic [2:0]  nzp_q, nzp_d;
    logic        ben_q, ben_d;

    logic [15:0] bus, sr1_out, sr2_out, alu_b, alu_out, addr1, addr2, adder, pc_next;
    logic [2:0]  dr_sel, sr1_sel;

    assign dr_sel  = DRMUX ? 3'd7 : ir_q[11:9];
    assign sr1_sel = SR1MUX ? ir_q[11:9] : ir_q[8:6];

    lc3_reg_file u_reg_file (
        .Clk    (Clk),
        .Reset  (Reset),
        .we     (LD_REG),
        .waddr  (dr_sel),
        .wdata  (bus),
        .raddr1 (sr1_sel),
        .raddr2 (ir_q[2:0]),
        .rdata1 (sr1_out),
        .rdata2 (sr2_out)
    );

    always_comb begin
        alu_b = SR2MUX ? sext({11'h0, ir_q[4:0]}, 5) : sr2_out;
        case (ALUK)
            ALUK_PASS: alu_out = sr1_out;
            ALUK_ADD:  alu_out = sr1_out + alu_b;
            ALUK_AND:  alu_out = sr1_out & alu_b;
            default:   alu_out = ~sr1_out;
        endcase

        addr1 = ADDR1MUX ? pc_q : sr1_out;
        case (ADDR2MUX)
            ADDR2_ZERO: addr2 = 16'h0000;
            ADDR2_OFF6: addr2 = sext({10'h0, ir_q[5:0]}, 6);
            ADDR2_OFF9: addr2 = sext({7'h0, ir_q[8:0]}, 9);
            default:    addr2 = sext({5'h0, ir_q[10:0]}, 11);
        endcase
        adder = addr1 + addr2;

        if (GatePC)          bus = pc_q;
        else if (GateMDR)    bus = mdr_q;
        else if (GateALU)    bus = alu_out;
        else if (GateMARMUX) bus = adder;
        else                 bus = 16'h0000;

        case (PCMUX)
            PCMUX_INC:  pc_next = pc_q + 16'h0001;
            PCMUX_BUS:  pc_next = bus;
            PCMUX_ADDR: pc_next = adder;
            default:    pc_next = pc_q;
        endcase
    end

    always_comb begin
        pc_d  = LD_PC  ? pc_next : pc_q;
        mar_d = LD_MAR ? bus : mar_q;
        mdr_d = LD_MDR ? (Mem_OE ? bus : Data_from_SRAM) : mdr_q;
        ir_d  = LD_IR  ? bus : ir_q;
        led_d = LD_LED ? ir_q[11:0] : led_q;
        ben_d = LD_BEN ? |(ir_q[11:9] & nzp_q) : ben_q;
        nzp_d = nzp_q;
        if (LD_CC) begin
            if (bus[15])              nzp_d = 3'b100;
            else if (bus == 16'h0000) nzp_d = 3'b010;
            else                      nzp_d = 3'b001;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q  <= 16'h0000;
            mar_q <= 16'h0000;
            mdr_q <= 16'h0000;
            ir_q  <= 16'h0000;
            led_q <= 12'h000;
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            ir_q  <= ir_d;
            led_q <= led_d;
            nzp_q <= nzp_d;
            ben_q <= ben_d;
        end
    end

`ifdef LC3_BUS_CHECK_EN
    logic bus_err_q, bus_err_d, multi_gate;

    assign multi_gate = ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1);

    always_comb begin
        bus_err_d = bus_err_q | multi_gate;
    end

    always_ff @(posedge Clk) begin
        if (Reset) bus_err_q <= 1'b0;
        else       bus_err_q <= bus_err_d;
        if (!Reset) assert (!multi_gate) else $warning("lc3_datapath: bus contention");
    end

    assign Bus_Err = bus_err_q;
`else
    assign Bus_Err = 1'b0;
`endif

    assign Opcode = ir_q[15:12];
    assign IR_5   = ir_q[5];
    assign IR_11  = ir_q[11];
    assign BEN    = ben_q;
    assign MAR    = mar_q;
    assign MDR    = mdr_q;
    assign PC_out = pc_q;
    assign IR_out = ir_q;
    assign LED    = led_q;
endmodule
